// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer, mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add a parity bit and the par_err check.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx_in,
  input  logic                 fall,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 par_err,
  output logic                 frm_err
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif

  state_e                 state_q, state_d;
  logic [SW-1:0]          s_cnt_q, s_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frm_err_q, frm_err_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   par_err_q, par_err_d;
`endif

  logic s_half_hit;
  logic s_last_hit;

  assign s_half_hit = tick && (s_cnt_q == S_HALF);
  assign s_last_hit = tick && (s_cnt_q == S_LAST);

  // State and datapath registers, synchronous reset abandons any frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      frm_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frm_err_q  <= frm_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Next-state: advance on sampling ticks, reject a start glitch
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (s_half_hit) state_d = rx_in ? IDLE : DATA;
      end
      DATA: begin
        if (s_last_hit && (bit_cnt_q == B_LAST)) state_d = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_last_hit) state_d = STOP;
      end
`endif
      STOP: begin
        if (s_last_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift register and result capture for each state
  always_comb begin
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    frm_err_d  = frm_err_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    par_err_d  = par_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall) s_cnt_d = '0;
      end
      START: begin
        if (s_half_hit) begin
          if (!rx_in) begin
            s_cnt_d   = '0;
            bit_cnt_d = '0;
          end
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (s_last_hit) begin
          shift_d = {rx_in, shift_q[DATA_BITS-1:1]};
          s_cnt_d = '0;
          if (bit_cnt_q != B_LAST) bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_last_hit) begin
          par_bad_d = ((^shift_q) ^ rx_in) != PARITY_ODD;
          s_cnt_d   = '0;
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (s_last_hit) begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
          frm_err_d  = ~rx_in;
          s_cnt_d    = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d  = par_bad_q;
`endif
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      default: begin
        s_cnt_d = '0;
      end
    endcase
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_busy  = (state_q != IDLE);
  assign frm_err  = frm_err_q;
`ifdef UART_RX_PARITY_EN
  assign par_err  = par_err_q;
`else
  // No parity bit on the line: flag is constant low, sense is irrelevant
  assign par_err  = PARITY_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table vectors, corner sequences and random frames
// against a frame-level reference model of the UART receiver.
module tb_uart_rx_ctrl;

  localparam int DB     = 8;
  localparam int OS     = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OS * TDIV;
  localparam bit PODD   = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          tick;
  logic          rx_in;
  logic          fall;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          par_err;
  logic          frm_err;

  uart_rx_ctrl #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .PARITY_ODD(PODD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .rx_in   (rx_in),
    .fall    (fall),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_busy (rx_busy),
    .par_err (par_err),
    .frm_err (frm_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    bit         pb;
    bit         sb;
    logic [7:0] ed;
    bit         ef;
    bit         ep;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         f;
    bit         p;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   nvalid = 0;
  int   ph = 0;
  bit   line = 1'b1;
  bit   prev_line = 1'b1;
  bit   prev_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after posedge
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    tick      = (ph == 0);
    ph        = (ph + 1) % TDIV;
    rx_in     = line;
    fall      = prev_line & ~line;
    prev_line = line;
    @(posedge clk);
    #1;
    if (rx_valid) begin
      nvalid++;
      check("valid_1clk", 32'(prev_valid), 32'd0);
      check("busy_at_valid", 32'(rx_busy), 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %0h, required no valid",
                 rx_data);
      end else begin
        e = expq.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.d));
        check("frm_err", 32'(frm_err), 32'(e.f));
        check("par_err", 32'(par_err), 32'(e.p));
      end
    end
    prev_valid = rx_valid;
  endtask

  task automatic hold(input bit b, input int n);
    line = b;
    repeat (n) cyc();
  endtask

  // Serialise one frame; b2b ends the stop bit as soon as valid is seen
  task automatic send_frame(input logic [7:0] d, input bit pb,
                            input bit sb, input logic [7:0] ed,
                            input bit ef, input bit ep, input bit b2b);
    exp_t e;
    int   n0;
    e.d = ed;
    e.f = ef;
    e.p = PAR_EN ? ep : 1'b0;
    expq.push_back(e);
    hold(1'b0, BITCLK);
    for (int i = 0; i < DB; i++) hold(d[i], BITCLK);
    if (PAR_EN) hold(pb, BITCLK);
    if (b2b) begin
      line = sb;
      n0 = nvalid;
      for (int k = 0; k < 2 * BITCLK && nvalid == n0; k++) cyc();
      check("b2b_valid_seen", 32'(nvalid - n0), 32'd1);
      ph = 0;
    end else begin
      hold(sb, BITCLK);
    end
  endtask

  function automatic bit ref_par(input logic [7:0] d, input bit pb);
    int ones;
    ones = $countones(d) + int'(pb);
    return (ones % 2) != int'(PODD);
  endfunction

  vec_t vecs[7];

  initial begin
    int         n0;
    logic [7:0] rd;
    bit         rp;
    bit         rs;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst   = 1'b1;
    tick  = 1'b0;
    rx_in = 1'b1;
    fall  = 1'b0;
    line  = 1'b1;
    repeat (3) cyc();
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_frm", 32'(frm_err), 32'd0);
    check("rst_par", 32'(par_err), 32'd0);
    rst = 1'b0;
    hold(1'b1, 10);
    check("idle_busy", 32'(rx_busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].d, vecs[v].pb, vecs[v].sb,
                 vecs[v].ed, vecs[v].ef, vecs[v].ep, 1'b0);
      hold(1'b1, 5);
    end
    check("table_valids", 32'(nvalid), 32'd7);

    n0 = nvalid;
    hold(1'b0, 3 * TDIV);
    check("glitch_busy_hi", 32'(rx_busy), 32'd1);
    hold(1'b1, 40);
    check("glitch_busy_lo", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", 32'(nvalid - n0), 32'd0);

    n0 = nvalid;
    hold(1'b0, BITCLK);
    hold(1'b1, 3 * BITCLK + 20);
    check("mid_busy", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_busy", 32'(rx_busy), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_frm", 32'(frm_err), 32'd0);
    hold(1'b1, 6 * BITCLK);
    check("mid_no_valid", 32'(nvalid - n0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 5);

    n0 = nvalid;
    send_frame(8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 5);
    check("b2b_valids", 32'(nvalid - n0), 32'd2);

    for (int r = 0; r < 30; r++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom % 4) != 0;
      send_frame(rd, rp, rs, rd, ~rs, ref_par(rd, rp), 1'b0);
      hold(1'b1, 2 + int'($urandom_range(0, 18)));
      ph = int'($urandom_range(0, TDIV - 1));
    end
    hold(1'b1, 10);

    check("frames_pending", 32'(expq.size()), 32'd0);
    check("busy_end", 32'(rx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-path sequencer for the UART Rx.
- Consumes the one-cycle falling-edge pulse from the Rx edge detector and a baud oversample tick, validates the start bit, samples data bits mid-bit (LSB first), checks stop bit (and parity when compiled in), and delivers a received byte with a one-cycle valid strobe.
- Sits between the Rx line conditioning (synchroniser + edge detector) and the Rx FIFO / host interface.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, ticks per bit period (even, >= 4).
- PARITY_ODD, 0, parity sense when PARITY checking is compiled in: 0 even, 1 odd.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  oversample strobe, one clk wide, OVERSAMPLE per bit period.
- rx_in  input  1  synchronised serial line, idle high.
- fall  input  1  one-cycle falling-edge pulse on rx_in from the edge detector.
- rx_data  output  DATA_BITS  last received word, LSB = first bit on the line.
- rx_valid  output  1  one-cycle pulse, rx_data/par_err/frm_err updated this cycle.
- rx_busy  output  1  high whenever state != IDLE.
- par_err  output  1  parity mismatch on last frame (0 when parity not compiled in).
- frm_err  output  1  stop bit sampled low on last frame.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, all counters 0, shift register 0, rx_data 0, rx_valid 0, par_err 0, frm_err 0. rx_busy reads 0. Applies mid-frame: the frame is abandoned, with no valid or error pulse.
- Counters: s_cnt of width clog2(OVERSAMPLE) counts ticks; bit_cnt of width clog2(DATA_BITS) counts data bits. Counters advance only on cycles with tick=1.
- IDLE: fall=1 -> START with s_cnt=0. tick is ignored. If fall and tick coincide, the transition is taken and the tick is not counted.
- START: on tick with s_cnt==OVERSAMPLE/2-1, sample rx_in.
  - rx_in=0 -> DATA with s_cnt=0 and bit_cnt=0.
  - rx_in=1 -> IDLE (glitch rejected, no outputs change).
  - Otherwise s_cnt++.
- DATA: on tick with s_cnt==OVERSAMPLE-1, shift rx_in into the MSB of the shift register (right shift) and set s_cnt=0.
  - If bit_cnt==DATA_BITS-1 -> PARITY (if compiled in) else STOP.
  - Otherwise bit_cnt++.
  - Otherwise s_cnt++.
- PARITY (compiled in only): on tick with s_cnt==OVERSAMPLE-1, capture par_bad = (^shift ^ rx_in) != PARITY_ODD, set s_cnt=0, then -> STOP.
- STOP: on tick with s_cnt==OVERSAMPLE-1, in the same cycle:
  - rx_data <= shift, rx_valid <= 1, frm_err <= ~rx_in, par_err <= par_bad.
  - -> IDLE.
- rx_valid is high for exactly one clk, in the cycle after the final stop-bit sampling edge. It is asserted even when errors are flagged.
- rx_data, par_err and frm_err hold until the next rx_valid.
- fall pulses outside IDLE are ignored.
- Back-to-back frames: a fall arriving in the clk immediately after the return to IDLE starts the next frame with no lost cycles.
- Sampling points: start bit at mid-bit; each data, parity and stop bit one full bit period after the previous sample, i.e. mid-bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state exists, one parity bit follows the data bits, and par_err reflects the check using PARITY_ODD.
- Undefined: there is no PARITY state, DATA goes directly to STOP, par_err is tied 0, and PARITY_ODD is unused.

Test Plan:
- Common setup: OVERSAMPLE=16, DATA_BITS=8, tick every 4 clk.
- Frame 0xA5 with valid stop bit, parity off -> exactly one rx_valid, rx_data=0xA5, par_err=0, frm_err=0, rx_busy low after valid.
- rx_in low for only 3 ticks after fall, then high -> returns to IDLE at the start-bit sample, no rx_valid, rx_busy drops.
- Frame 0x3C with stop bit driven 0 -> rx_valid with rx_data=0x3C and frm_err=1. Next good frame 0x01 -> frm_err=0.
- UART_RX_PARITY_EN defined, PARITY_ODD=0, frame 0xA5 with parity bit 1 -> par_err=1. Same frame with parity bit 0 -> par_err=0.
- rst pulsed during the 4th data bit of 0xFF -> no rx_valid, state IDLE, outputs 0. A following frame 0x5A is received correctly.
- Two back-to-back frames 0x12, 0x34 with fall on the first idle cycle, plus fall coinciding with tick -> two valids, data 0x12 then 0x34.
